game_sequencer: RTL and testbench

//  Top-level game controller for the memorisation game. Sequences one round:

---
 rtl/game_sequencer_pkg.sv | 23 ++
 rtl/sync_edge.sv | 40 ++++
 rtl/game_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_game_sequencer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/game_sequencer_pkg.sv
// Shared definitions for the memorisation game controller: FSM state
// encodings, BCD digit constants and a small elaboration-time helper.
package game_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SHOW   = 3'd2,
        ST_ENTER  = 3'd3,
        ST_CHECK  = 3'd4,
        ST_RESULT = 3'd5
    } state_e;

    localparam int         DIGIT_W = 4;
    localparam logic [3:0] BCD_MAX = 4'd9;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser for an asynchronous button level, producing a
// one-cycle pulse on each rising edge of the synchronised level.
module sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic rise
);

    logic       s1_q, s1_d;
    logic       s2_q, s2_d;
    logic       prev_q, prev_d;
    logic [2:0] vld_q, vld_d;

    // vld marks which stages hold real samples, so a level held high
    // across reset release never looks like a fresh press.
    always_comb begin
        s1_d   = async_in;
        s2_d   = s1_q;
        prev_d = s2_q;
        vld_d  = {vld_q[1:0], 1'b1};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            prev_q <= 1'b0;
            vld_q  <= 3'b000;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            prev_q <= prev_d;
            vld_q  <= vld_d;
        end
    end

    assign rise = s2_q & ~prev_q & vld_q[2];

endmodule

// File: rtl/game_sequencer.sv
// Round sequencer for the memorisation game: captures a random target,
// shows it, collects keypad digits, compares and displays the result.
module game_sequencer
    import game_sequencer_pkg::*;
#(
    parameter int DIGITS       = 4,
    parameter int SHOW_TICKS   = 6,
    parameter int ENTER_TICKS  = 20,
    parameter int RESULT_TICKS = 4,
    parameter int SCORE_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  tick,
    input  logic [4*DIGITS-1:0]   rand_int,
    input  logic                  key_valid,
    input  logic [3:0]            key_value,
    output logic [4*DIGITS-1:0]   target,
    output logic [4*DIGITS-1:0]   user_value,
    output logic [2:0]            digit_count,
    output logic                  display_phase,
    output logic                  enter_phase,
    output logic                  result_phase,
    output logic                  correct,
    output logic                  timeout,
    output logic                  round_done,
    output logic [SCORE_W-1:0]    score
);

    localparam int VAL_W     = DIGIT_W * DIGITS;
    localparam int MAX_TICKS = max3(SHOW_TICKS, ENTER_TICKS, RESULT_TICKS);
    localparam int CNT_W     = $clog2(MAX_TICKS + 1);

    localparam logic [CNT_W-1:0] SHOW_LAST   = CNT_W'(SHOW_TICKS - 1);
    localparam logic [CNT_W-1:0] ENTER_LAST  = CNT_W'(ENTER_TICKS - 1);
    localparam logic [CNT_W-1:0] RESULT_LAST = CNT_W'(RESULT_TICKS - 1);
    localparam logic [2:0]       LAST_DIGIT  = 3'(DIGITS - 1);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [VAL_W-1:0]     target_q, target_d;
    logic [VAL_W-1:0]     user_q, user_d;
    logic [2:0]           count_q, count_d;
    logic                 correct_q, correct_d;
    logic                 timeout_q, timeout_d;
    logic                 round_done_q, round_done_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic                 display_q, display_d;
    logic                 enter_q, enter_d;
    logic                 result_q, result_d;

    logic start_evt;
    logic digit_ok;

    sync_edge u_start_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (start),
        .rise     (start_evt)
    );

    assign digit_ok = key_valid && (key_value <= BCD_MAX);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        target_d     = target_q;
        user_d       = user_q;
        count_d      = count_q;
        correct_d    = correct_q;
        timeout_d    = timeout_q;
        score_d      = score_q;
        round_done_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_evt) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                target_d  = rand_int;
                user_d    = '0;
                count_d   = '0;
                correct_d = 1'b0;
                timeout_d = 1'b0;
                cnt_d     = '0;
                state_d   = ST_SHOW;
            end
            ST_SHOW: begin
                if (tick) begin
                    if (cnt_q == SHOW_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_ENTER;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_ENTER: begin
                if (digit_ok) begin
                    user_d  = {user_q[VAL_W-DIGIT_W-1:0], key_value};
                    count_d = count_q + 3'd1;
                end
                // A final digit landing on the timeout tick still counts as entry.
                if (digit_ok && count_q == LAST_DIGIT) begin
                    state_d = ST_CHECK;
                end else if (tick && cnt_q == ENTER_LAST) begin
                    state_d   = ST_RESULT;
                    timeout_d = 1'b1;
                    correct_d = 1'b0;
                    score_d   = '0;
                    cnt_d     = '0;
                end else if (tick) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_CHECK: begin
                correct_d = (user_q == target_q);
                if (user_q == target_q) begin
                    if (!(&score_q)) score_d = score_q + SCORE_W'(1);
                end else begin
                    score_d = '0;
                end
                cnt_d   = '0;
                state_d = ST_RESULT;
            end
            ST_RESULT: begin
                if (tick) begin
                    if (cnt_q == RESULT_LAST) begin
                        cnt_d        = '0;
                        state_d      = ST_IDLE;
                        round_done_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        display_d = (state_d == ST_SHOW);
        enter_d   = (state_d == ST_ENTER);
        result_d  = (state_d == ST_RESULT);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            target_q     <= '0;
            user_q       <= '0;
            count_q      <= '0;
            correct_q    <= 1'b0;
            timeout_q    <= 1'b0;
            round_done_q <= 1'b0;
            score_q      <= '0;
            display_q    <= 1'b0;
            enter_q      <= 1'b0;
            result_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            target_q     <= target_d;
            user_q       <= user_d;
            count_q      <= count_d;
            correct_q    <= correct_d;
            timeout_q    <= timeout_d;
            round_done_q <= round_done_d;
            score_q      <= score_d;
            display_q    <= display_d;
            enter_q      <= enter_d;
            result_q     <= result_d;
        end
    end

    assign target        = target_q;
    assign user_value    = user_q;
    assign digit_count   = count_q;
    assign display_phase = display_q;
    assign enter_phase   = enter_q;
    assign result_phase  = result_q;
    assign correct       = correct_q;
    assign timeout       = timeout_q;
    assign round_done    = round_done_q;
    assign score         = score_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed testbench for game_sequencer: one task per scenario, each with
// hand-computed expected values checked on the falling clock edge.
module tb_game_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        tick;
    logic [15:0] rand_int;
    logic        key_valid;
    logic [3:0]  key_value;
    logic [15:0] target;
    logic [15:0] user_value;
    logic [2:0]  digit_count;
    logic        display_phase;
    logic        enter_phase;
    logic        result_phase;
    logic        correct;
    logic        timeout;
    logic        round_done;
    logic [7:0]  score;

    int pass_cnt  = 0;
    int check_cnt = 0;

    game_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .tick          (tick),
        .rand_int      (rand_int),
        .key_valid     (key_valid),
        .key_value     (key_value),
        .target        (target),
        .user_value    (user_value),
        .digit_count   (digit_count),
        .display_phase (display_phase),
        .enter_phase   (enter_phase),
        .result_phase  (result_phase),
        .correct       (correct),
        .timeout       (timeout),
        .round_done    (round_done),
        .score         (score)
    );

    always #5 clk = ~clk;

    task automatic pulse_tick();
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic send_key(input logic [3:0] v);
        key_valid = 1'b1;
        key_value = v;
        @(negedge clk);
        key_valid = 1'b0;
        key_value = 4'd0;
    endtask

    task automatic start_round(input logic [15:0] value, output bit ok);
        ok       = 1'b0;
        rand_int = value;
        start    = 1'b0;
        repeat (5) @(negedge clk);
        start = 1'b1;
        for (int i = 0; i < 12 && !ok; i++) begin
            @(negedge clk);
            if (display_phase) ok = 1'b1;
        end
        start = 1'b0;
    endtask

    task automatic run_round(input logic [15:0] value, input logic [15:0] keys, output bit ok);
        start_round(value, ok);
        repeat (6) pulse_tick();
        for (int d = 0; d < 4; d++) send_key(keys[15-4*d -: 4]);
        @(negedge clk);
        repeat (4) pulse_tick();
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b1; tick = 1'b0;
        rand_int = 16'h4821; key_valid = 1'b0; key_value = 4'd0;
        repeat (3) @(negedge clk);
        check_cnt++; if (target !== 16'h0) $display("[TB] FAIL reset_target: got %h want 0000", target); else pass_cnt++;
        check_cnt++; if (user_value !== 16'h0) $display("[TB] FAIL reset_user: got %h want 0000", user_value); else pass_cnt++;
        check_cnt++; if (digit_count !== 3'd0) $display("[TB] FAIL reset_count: got %0d want 0", digit_count); else pass_cnt++;
        check_cnt++; if ({display_phase, enter_phase, result_phase} !== 3'b000) $display("[TB] FAIL reset_phases: got %b want 000", {display_phase, enter_phase, result_phase}); else pass_cnt++;
        check_cnt++; if ({correct, timeout, round_done} !== 3'b000) $display("[TB] FAIL reset_flags: got %b want 000", {correct, timeout, round_done}); else pass_cnt++;
        check_cnt++; if (score !== 8'd0) $display("[TB] FAIL reset_score: got %0d want 0", score); else pass_cnt++;
        rst = 1'b1;
        repeat (10) @(negedge clk);
        check_cnt++; if (display_phase !== 1'b0) $display("[TB] FAIL held_start_no_show: got %b want 0", display_phase); else pass_cnt++;
        check_cnt++; if (target !== 16'h0) $display("[TB] FAIL held_start_no_load: got %h want 0000", target); else pass_cnt++;
        start = 1'b0;
    endtask

    task automatic test_show();
        bit ok;
        start_round(16'h4821, ok);
        check_cnt++; if (!ok) $display("[TB] FAIL show_start: got no display_phase want display_phase within 12 cycles"); else pass_cnt++;
        check_cnt++; if (target !== 16'h4821) $display("[TB] FAIL show_target: got %h want 4821", target); else pass_cnt++;
        send_key(4'd7);
        check_cnt++; if (digit_count !== 3'd0 || user_value !== 16'h0) $display("[TB] FAIL show_key_dropped: got %0d/%h want 0/0000", digit_count, user_value); else pass_cnt++;
        for (int i = 1; i <= 5; i++) begin
            pulse_tick();
            check_cnt++; if (display_phase !== 1'b1 || enter_phase !== 1'b0) $display("[TB] FAIL show_tick%0d: got disp=%b ent=%b want 1/0", i, display_phase, enter_phase); else pass_cnt++;
        end
        pulse_tick();
        check_cnt++; if (display_phase !== 1'b0 || enter_phase !== 1'b1) $display("[TB] FAIL show_to_enter: got disp=%b ent=%b want 0/1", display_phase, enter_phase); else pass_cnt++;
    endtask

    task automatic test_correct();
        send_key(4'd4);
        send_key(4'd8);
        send_key(4'hA);
        check_cnt++; if (digit_count !== 3'd2 || user_value !== 16'h0048) $display("[TB] FAIL key_A_ignored: got %0d/%h want 2/0048", digit_count, user_value); else pass_cnt++;
        send_key(4'd2);
        send_key(4'd1);
        check_cnt++; if (digit_count !== 3'd4 || user_value !== 16'h4821) $display("[TB] FAIL entry_value: got %0d/%h want 4/4821", digit_count, user_value); else pass_cnt++;
        check_cnt++; if ({enter_phase, result_phase} !== 2'b00) $display("[TB] FAIL check_phase: got %b want 00", {enter_phase, result_phase}); else pass_cnt++;
        @(negedge clk);
        check_cnt++; if (result_phase !== 1'b1 || correct !== 1'b1 || timeout !== 1'b0) $display("[TB] FAIL correct_result: got res=%b cor=%b to=%b want 1/1/0", result_phase, correct, timeout); else pass_cnt++;
        check_cnt++; if (score !== 8'd1) $display("[TB] FAIL correct_score: got %0d want 1", score); else pass_cnt++;
        send_key(4'd5);
        check_cnt++; if (user_value !== 16'h4821 || digit_count !== 3'd4) $display("[TB] FAIL result_key_dropped: got %h/%0d want 4821/4", user_value, digit_count); else pass_cnt++;
        for (int i = 1; i <= 3; i++) begin
            pulse_tick();
            check_cnt++; if (result_phase !== 1'b1 || round_done !== 1'b0) $display("[TB] FAIL result_tick%0d: got res=%b done=%b want 1/0", i, result_phase, round_done); else pass_cnt++;
        end
        pulse_tick();
        check_cnt++; if (result_phase !== 1'b0 || round_done !== 1'b1) $display("[TB] FAIL round_done_pulse: got res=%b done=%b want 0/1", result_phase, round_done); else pass_cnt++;
        @(negedge clk);
        check_cnt++; if (round_done !== 1'b0 || correct !== 1'b1 || target !== 16'h4821) $display("[TB] FAIL idle_hold: got done=%b cor=%b tgt=%h want 0/1/4821", round_done, correct, target); else pass_cnt++;
    endtask

    task automatic test_wrong();
        bit ok;
        start_round(16'h4821, ok);
        check_cnt++; if (!ok) $display("[TB] FAIL wrong_start: got no display_phase want display_phase within 12 cycles"); else pass_cnt++;
        repeat (6) pulse_tick();
        send_key(4'd4); send_key(4'd8); send_key(4'd2); send_key(4'd0);
        @(negedge clk);
        check_cnt++; if (result_phase !== 1'b1 || correct !== 1'b0 || timeout !== 1'b0) $display("[TB] FAIL wrong_result: got res=%b cor=%b to=%b want 1/0/0", result_phase, correct, timeout); else pass_cnt++;
        check_cnt++; if (score !== 8'd0) $display("[TB] FAIL wrong_score: got %0d want 0", score); else pass_cnt++;
        repeat (4) pulse_tick();
    endtask

    task automatic test_timeout();
        bit ok;
        start_round(16'h1357, ok);
        check_cnt++; if (!ok) $display("[TB] FAIL timeout_start: got no display_phase want display_phase within 12 cycles"); else pass_cnt++;
        repeat (6) pulse_tick();
        send_key(4'd1); send_key(4'd3);
        repeat (19) pulse_tick();
        check_cnt++; if (enter_phase !== 1'b1) $display("[TB] FAIL timeout_tick19: got ent=%b want 1", enter_phase); else pass_cnt++;
        pulse_tick();
        check_cnt++; if (result_phase !== 1'b1 || timeout !== 1'b1 || correct !== 1'b0) $display("[TB] FAIL timeout_result: got res=%b to=%b cor=%b want 1/1/0", result_phase, timeout, correct); else pass_cnt++;
        check_cnt++; if (digit_count !== 3'd2 || user_value !== 16'h0013) $display("[TB] FAIL timeout_digits: got %0d/%h want 2/0013", digit_count, user_value); else pass_cnt++;
        repeat (4) pulse_tick();
    endtask

    task automatic test_simultaneous();
        bit ok;
        start_round(16'h2468, ok);
        check_cnt++; if (!ok) $display("[TB] FAIL simul_start: got no display_phase want display_phase within 12 cycles"); else pass_cnt++;
        repeat (6) pulse_tick();
        send_key(4'd2); send_key(4'd4); send_key(4'd6);
        repeat (19) pulse_tick();
        key_valid = 1'b1; key_value = 4'd8; tick = 1'b1;
        @(negedge clk);
        key_valid = 1'b0; key_value = 4'd0; tick = 1'b0;
        check_cnt++; if ({enter_phase, result_phase, timeout} !== 3'b000 || digit_count !== 3'd4) $display("[TB] FAIL simul_check: got ent/res/to=%b cnt=%0d want 000/4", {enter_phase, result_phase, timeout}, digit_count); else pass_cnt++;
        @(negedge clk);
        check_cnt++; if (result_phase !== 1'b1 || correct !== 1'b1 || timeout !== 1'b0) $display("[TB] FAIL simul_result: got res=%b cor=%b to=%b want 1/1/0", result_phase, correct, timeout); else pass_cnt++;
        check_cnt++; if (score !== 8'd1) $display("[TB] FAIL simul_score: got %0d want 1", score); else pass_cnt++;
        repeat (4) pulse_tick();
    endtask

    task automatic test_reset_mid();
        bit ok;
        start_round(16'h9999, ok);
        check_cnt++; if (!ok) $display("[TB] FAIL mid_start: got no display_phase want display_phase within 12 cycles"); else pass_cnt++;
        repeat (6) pulse_tick();
        send_key(4'd9);
        check_cnt++; if (enter_phase !== 1'b1 || digit_count !== 3'd1 || score !== 8'd1) $display("[TB] FAIL mid_before: got ent=%b cnt=%0d score=%0d want 1/1/1", enter_phase, digit_count, score); else pass_cnt++;
        #2 rst = 1'b0;
        #1;
        check_cnt++; if (enter_phase !== 1'b0 || digit_count !== 3'd0 || score !== 8'd0) $display("[TB] FAIL mid_reset: got ent=%b cnt=%0d score=%0d want 0/0/0", enter_phase, digit_count, score); else pass_cnt++;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_saturate();
        bit ok;
        bit all_ok;
        logic [15:0] v;
        all_ok = 1'b1;
        for (int r = 0; r < 255; r++) begin
            v = 16'h0;
            for (int d = 0; d < 4; d++) v = {v[11:0], 4'($urandom_range(0, 9))};
            run_round(v, v, ok);
            if (!ok) all_ok = 1'b0;
        end
        check_cnt++; if (!all_ok) $display("[TB] FAIL sat_rounds_started: got a round without display_phase want all started"); else pass_cnt++;
        check_cnt++; if (score !== 8'd255) $display("[TB] FAIL sat_255: got %0d want 255", score); else pass_cnt++;
        run_round(16'h3141, 16'h3141, ok);
        check_cnt++; if (!ok || score !== 8'd255) $display("[TB] FAIL sat_hold: got ok=%b score=%0d want 1/255", ok, score); else pass_cnt++;
        run_round(16'h3141, 16'h3142, ok);
        check_cnt++; if (!ok || score !== 8'd0) $display("[TB] FAIL sat_miss_clear: got ok=%b score=%0d want 1/0", ok, score); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_show();
        test_correct();
        test_wrong();
        test_timeout();
        test_simultaneous();
        test_reset_mid();
        test_saturate();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
